// File: rtl/intersection_sequencer.sv
// N-way intersection controller: round-robin green rotation with yellow and all-red
// clearance, priority preemption, per-way force-red skipping and flashing-yellow attention.
module intersection_sequencer #(
    parameter int N_WAYS    = 4,
    parameter int TIMER_W   = 8,
    parameter int GREEN_T   = 20,
    parameter int MIN_GREEN = 5,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tick,
    input  logic                        attention,
    input  logic [N_WAYS-1:0]           force_red,
    input  logic [N_WAYS-1:0]           preferential,
    output logic [N_WAYS*3-1:0]         lights,
    output logic [$clog2(N_WAYS)-1:0]   active_way,
    output logic [2:0]                  phase
);
    localparam int AW = $clog2(N_WAYS);

    typedef enum logic [2:0] {
        ST_ALL_RED = 3'd0,
        ST_GREEN   = 3'd1,
        ST_YELLOW  = 3'd2,
        ST_FLASH   = 3'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [TIMER_W-1:0]  cnt_reg, cnt_next;
    logic [AW-1:0]       last_way_reg, last_way_next;
    logic [AW-1:0]       active_way_reg, active_way_next;
    logic                flash_on_reg, flash_on_next;
    logic [N_WAYS*3-1:0] lights_reg, lights_next;

    logic [N_WAYS-1:0]   cand, pref_cand, active_mask;
    logic [AW-1:0]       pick;
    logic                any_cand, expire, preempt;

    // Preferential requests win (lowest index); otherwise the first candidate after last_way.
    always_comb begin
        cand      = ~force_red;
        pref_cand = cand & preferential;
        any_cand  = |cand;
        pick      = '0;
        if (|pref_cand) begin
            for (int i = N_WAYS - 1; i >= 0; i--) begin
                if (pref_cand[i]) pick = AW'(i);
            end
        end else begin
            for (int k = N_WAYS; k >= 1; k--) begin
                if (cand[(int'(last_way_reg) + k) % N_WAYS])
                    pick = AW'((int'(last_way_reg) + k) % N_WAYS);
            end
        end
    end

    assign active_mask = N_WAYS'(1) << active_way_reg;
    assign expire      = tick && (cnt_reg == '0);
    // elapsed >= MIN_GREEN rewritten as a bound on the down-counter
    assign preempt     = tick && (|(pref_cand & ~active_mask))
                         && (cnt_reg <= TIMER_W'(GREEN_T - 1 - MIN_GREEN));

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        last_way_next   = last_way_reg;
        active_way_next = active_way_reg;
        flash_on_next   = flash_on_reg;
        if (tick && cnt_reg != '0)
            cnt_next = cnt_reg - TIMER_W'(1);

        if (attention) begin
            if (state_reg != ST_FLASH) begin
                state_next    = ST_FLASH;
                flash_on_next = 1'b1;
            end else if (tick) begin
                flash_on_next = ~flash_on_reg;
            end
        end else begin
            case (state_reg)
                ST_ALL_RED: begin
                    if (expire) begin
                        if (any_cand) begin
                            state_next      = ST_GREEN;
                            active_way_next = pick;
                            last_way_next   = pick;
                            cnt_next        = TIMER_W'(GREEN_T - 1);
                        end else begin
                            cnt_next = TIMER_W'(ALLRED_T - 1);
                        end
                    end
                end
                ST_GREEN: begin
                    if (force_red[active_way_reg] || expire || preempt) begin
                        state_next = ST_YELLOW;
                        cnt_next   = TIMER_W'(YELLOW_T - 1);
                    end
                end
                ST_YELLOW: begin
                    if (expire) begin
                        state_next = ST_ALL_RED;
                        cnt_next   = TIMER_W'(ALLRED_T - 1);
                    end
                end
                default: begin
                    state_next    = ST_ALL_RED;
                    cnt_next      = TIMER_W'(ALLRED_T - 1);
                    flash_on_next = 1'b0;
                end
            endcase
        end
    end

    // Lamps are decoded from the next state so they register alongside phase.
    for (genvar gi = 0; gi < N_WAYS; gi++) begin : g_lamp
        logic [2:0] lamp;
        always_comb begin
            lamp = 3'b100;
            case (state_next)
                ST_GREEN:  if (active_way_next == AW'(gi)) lamp = 3'b001;
                ST_YELLOW: if (active_way_next == AW'(gi)) lamp = 3'b010;
                ST_FLASH:  lamp = flash_on_next ? 3'b010 : 3'b000;
                default:   lamp = 3'b100;
            endcase
        end
        assign lights_next[3*gi +: 3] = lamp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_ALL_RED;
            cnt_reg        <= TIMER_W'(ALLRED_T - 1);
            last_way_reg   <= AW'(N_WAYS - 1);
            active_way_reg <= '0;
            flash_on_reg   <= 1'b0;
            lights_reg     <= {N_WAYS{3'b100}};
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            last_way_reg   <= last_way_next;
            active_way_reg <= active_way_next;
            flash_on_reg   <= flash_on_next;
            lights_reg     <= lights_next;
        end
    end

    assign lights     = lights_reg;
    assign active_way = active_way_reg;
    assign phase      = state_reg;
endmodule

// File: tb/tb_intersection_sequencer.sv
// Directed bench for intersection_sequencer: rotation, skipping, preemption, attention, reset.
module tb_intersection_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        attention;
    logic [3:0]  force_red;
    logic [3:0]  preferential;
    logic [11:0] lights;
    logic [1:0]  active_way;
    logic [2:0]  phase;

    int vectors = 0;
    int errors  = 0;

    localparam logic [11:0] ALL_RED_L = 12'h924;
    localparam logic [11:0] FLASH_L   = 12'h492;

    intersection_sequencer #(
        .N_WAYS(4), .TIMER_W(8), .GREEN_T(4), .MIN_GREEN(2), .YELLOW_T(2), .ALLRED_T(1)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .attention(attention),
        .force_red(force_red), .preferential(preferential),
        .lights(lights), .active_way(active_way), .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] lamp(input int way, input logic [2:0] pat);
        logic [11:0] l;
        l = ALL_RED_L;
        l[3*way +: 3] = pat;
        return l;
    endfunction

    task automatic reset_dut();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Follows one green/yellow/all-red cycle and reports what it saw.
    task automatic observe(output int way, output int glen, output int ylen, output int rlen,
                           output logic [11:0] g_l, output logic [11:0] y_l,
                           output logic [3:0] nonred);
        int n;
        way = -1; glen = 0; ylen = 0; rlen = 0; g_l = '0; y_l = '0; nonred = '0;
        n = 0;
        while (phase != 3'd1 && n < 40) begin step(); n++; end
        if (phase != 3'd1) return;
        way = int'(active_way);
        g_l = lights;
        while (phase == 3'd1 && glen < 40) begin
            for (int w = 0; w < 4; w++) if (lights[3*w +: 3] != 3'b100) nonred[w] = 1'b1;
            glen++; step();
        end
        y_l = lights;
        while (phase == 3'd2 && ylen < 40) begin
            for (int w = 0; w < 4; w++) if (lights[3*w +: 3] != 3'b100) nonred[w] = 1'b1;
            ylen++; step();
        end
        while (phase == 3'd0 && rlen < 40) begin rlen++; step(); end
    endtask

    task automatic test_reset();
        attention = 1'b1; force_red = 4'b0000; preferential = 4'b1111;
        rst = 1'b1;
        step(); step();
        vectors++;
        if (lights !== ALL_RED_L) begin errors++; $display("FAIL reset_lights: got %h expected %h", lights, ALL_RED_L); end
        vectors++;
        if (phase !== 3'd0) begin errors++; $display("FAIL reset_phase: got %0d expected 0", phase); end
        vectors++;
        if (active_way !== 2'd0) begin errors++; $display("FAIL reset_active: got %0d expected 0", active_way); end
        attention = 1'b0; preferential = 4'b0000;
        rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_rotation();
        int w, g, y, r; logic [11:0] gl, yl; logic [3:0] nr;
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            observe(w, g, y, r, gl, yl, nr);
            vectors++;
            if (w !== i % 4) begin errors++; $display("FAIL rot_way[%0d]: got %0d expected %0d", i, w, i % 4); end
            vectors++;
            if (g !== 4 || y !== 2 || r !== 1) begin errors++; $display("FAIL rot_len[%0d]: got g%0d y%0d r%0d expected g4 y2 r1", i, g, y, r); end
            vectors++;
            if (gl !== lamp(i % 4, 3'b001) || yl !== lamp(i % 4, 3'b010)) begin
                errors++; $display("FAIL rot_lamps[%0d]: got %h/%h expected %h/%h", i, gl, yl, lamp(i % 4, 3'b001), lamp(i % 4, 3'b010));
            end
            $display("rotation green way %0d g=%0d y=%0d r=%0d", w, g, y, r);
        end
    endtask

    task automatic test_force_skip();
        int w, g, y, r; logic [11:0] gl, yl; logic [3:0] nr; logic [3:0] acc;
        int exp_w [4] = '{0, 2, 3, 0};
        force_red = 4'b0010;
        reset_dut();
        acc = '0;
        for (int i = 0; i < 4; i++) begin
            observe(w, g, y, r, gl, yl, nr);
            acc |= nr;
            vectors++;
            if (w !== exp_w[i]) begin errors++; $display("FAIL skip_way[%0d]: got %0d expected %0d", i, w, exp_w[i]); end
            $display("skip green way %0d", w);
        end
        vectors++;
        if (acc[1] !== 1'b0) begin errors++; $display("FAIL skip_way1_red: got nonred=%b expected bit1=0", acc); end
        force_red = 4'b0000;
    endtask

    task automatic test_preempt();
        int w, g, y, r; logic [11:0] gl, yl; logic [3:0] nr;
        reset_dut();
        step();
        preferential = 4'b1000;
        observe(w, g, y, r, gl, yl, nr);
        vectors++;
        if (w !== 0 || g !== 3) begin errors++; $display("FAIL preempt_green: got way%0d len%0d expected way0 len3", w, g); end
        vectors++;
        if (phase !== 3'd1 || active_way !== 2'd3) begin errors++; $display("FAIL preempt_target: got phase%0d way%0d expected phase1 way3", phase, active_way); end
        preferential = 4'b0000;
        observe(w, g, y, r, gl, yl, nr);
        vectors++;
        if (w !== 3 || g !== 4) begin errors++; $display("FAIL preempt_w3_len: got way%0d len%0d expected way3 len4", w, g); end
        observe(w, g, y, r, gl, yl, nr);
        vectors++;
        if (w !== 0) begin errors++; $display("FAIL preempt_resume: got %0d expected 0", w); end
        $display("preempt done, resumed at way %0d", w);
    endtask

    task automatic test_force_mid_green();
        int yl_cnt;
        reset_dut();
        step();
        step();
        force_red = 4'b0001;
        step();
        vectors++;
        if (phase !== 3'd2 || lights !== lamp(0, 3'b010)) begin errors++; $display("FAIL fr_yellow: got phase%0d lights %h expected phase2 %h", phase, lights, lamp(0, 3'b010)); end
        yl_cnt = 0;
        while (phase == 3'd2 && yl_cnt < 20) begin yl_cnt++; step(); end
        vectors++;
        if (yl_cnt !== 2) begin errors++; $display("FAIL fr_yellow_len: got %0d expected 2", yl_cnt); end
        step();
        vectors++;
        if (phase !== 3'd1 || active_way !== 2'd1) begin errors++; $display("FAIL fr_next: got phase%0d way%0d expected phase1 way1", phase, active_way); end
        force_red = 4'b0000;
        $display("force mid-green done");
    endtask

    task automatic test_attention();
        reset_dut();
        step();
        step();
        attention = 1'b1;
        step();
        vectors++;
        if (phase !== 3'd3 || lights !== FLASH_L) begin errors++; $display("FAIL att_enter: got phase%0d lights %h expected phase3 %h", phase, lights, FLASH_L); end
        step();
        vectors++;
        if (lights !== 12'h000) begin errors++; $display("FAIL att_off: got %h expected 000", lights); end
        step();
        vectors++;
        if (lights !== FLASH_L) begin errors++; $display("FAIL att_on: got %h expected %h", lights, FLASH_L); end
        attention = 1'b0;
        step();
        vectors++;
        if (phase !== 3'd0 || lights !== ALL_RED_L) begin errors++; $display("FAIL att_exit: got phase%0d lights %h expected phase0 %h", phase, lights, ALL_RED_L); end
        step();
        vectors++;
        if (phase !== 3'd1 || active_way !== 2'd1) begin errors++; $display("FAIL att_resume: got phase%0d way%0d expected phase1 way1", phase, active_way); end
        $display("attention done");
    endtask

    task automatic test_all_forced_and_reset();
        int bad; int n;
        force_red = 4'b1111;
        reset_dut();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (phase != 3'd0 || lights != ALL_RED_L) bad++;
        end
        vectors++;
        if (bad !== 0) begin errors++; $display("FAIL all_forced: got %0d non-red cycles expected 0", bad); end
        force_red = 4'b0000;
        step();
        vectors++;
        if (phase !== 3'd1 || active_way !== 2'd0) begin errors++; $display("FAIL all_forced_release: got phase%0d way%0d expected phase1 way0", phase, active_way); end
        n = 0;
        while (phase != 3'd2 && n < 20) begin step(); n++; end
        rst = 1'b1;
        step();
        vectors++;
        if (lights !== ALL_RED_L || phase !== 3'd0 || active_way !== 2'd0) begin
            errors++; $display("FAIL rst_mid_yellow: got phase%0d lights %h way%0d expected phase0 %h way0", phase, lights, active_way, ALL_RED_L);
        end
        rst = 1'b0;
        step();
        vectors++;
        if (phase !== 3'd1 || active_way !== 2'd0) begin errors++; $display("FAIL rst_first_green: got phase%0d way%0d expected phase1 way0", phase, active_way); end
        $display("all-forced and mid-yellow reset done");
    endtask

    initial begin
        rst = 1'b1; tick = 1'b1; attention = 1'b0; force_red = '0; preferential = '0;
        test_reset();
        test_rotation();
        test_force_skip();
        test_preempt();
        test_force_mid_green();
        test_attention();
        test_all_forced_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
